// File: rtl/iob_2p_mem_arbiter.sv
// ============================================================================
// Module      : iob_2p_mem_arbiter
// Description : Two-port round-robin arbiter in front of a single-port,
//               1-cycle-read tiled memory. Optional macro MEM_ARB_BURST_EN
//               lets a winner keep priority for up to BURST_LEN transfers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iob_2p_mem_arbiter #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic              a_we_i,
  input  logic [ADDR_W-1:0] a_addr_i,
  input  logic [DATA_W-1:0] a_wdata_i,
  output logic              a_rvalid_o,
  input  logic              b_valid_i,
  output logic              b_ready_o,
  input  logic              b_we_i,
  input  logic [ADDR_W-1:0] b_addr_i,
  input  logic [DATA_W-1:0] b_wdata_i,
  output logic              b_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_w_en_o,
  output logic              mem_r_en_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_in_o,
  input  logic [DATA_W-1:0] mem_data_out_i
);

  localparam logic PRIO_A = 1'b0;
  localparam logic PRIO_B = 1'b1;

  logic prio_q, prio_d;
  logic a_rvalid_q, b_rvalid_q;
  logic w_grant_a, w_grant_b, w_xfer, w_we, w_win;

  // Grants are gated by rst_n so nothing reaches the memory while in reset.
  assign w_grant_a = rst_n & a_valid_i & (~b_valid_i | (prio_q == PRIO_A));
  assign w_grant_b = rst_n & b_valid_i & (~a_valid_i | (prio_q == PRIO_B));
  assign w_xfer    = w_grant_a | w_grant_b;
  assign w_win     = w_grant_b ? PRIO_B : PRIO_A;
  assign w_we      = w_grant_b ? b_we_i : a_we_i;

  assign a_ready_o     = w_grant_a;
  assign b_ready_o     = w_grant_b;
  assign mem_w_en_o    = w_xfer & w_we;
  assign mem_r_en_o    = w_xfer & ~w_we;
  assign mem_addr_o    = w_grant_b ? b_addr_i  : a_addr_i;
  assign mem_data_in_o = w_grant_b ? b_wdata_i : a_wdata_i;
  assign rdata_o       = mem_data_out_i;
  assign a_rvalid_o    = a_rvalid_q;
  assign b_rvalid_o    = b_rvalid_q;

`ifdef MEM_ARB_BURST_EN
  localparam int BURST_LEN = 4;

  logic [1:0] cnt_q, cnt_d;
  logic       w_owner_valid;

  // prio_q doubles as the burst owner; cnt_q counts its consecutive transfers.
  assign w_owner_valid = (prio_q == PRIO_A) ? a_valid_i : b_valid_i;

  always_comb begin
    prio_d = prio_q;
    cnt_d  = cnt_q;
    if (w_xfer) begin
      if (w_win == prio_q) begin
        if (cnt_q == 2'(BURST_LEN - 1)) begin
          prio_d = ~prio_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end else begin
        prio_d = w_win;
        cnt_d  = 2'd1;
      end
    end else if (!w_owner_valid) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
`else
  always_comb begin
    prio_d = prio_q;
    if (w_xfer) prio_d = ~w_win;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prio_q     <= PRIO_A;
      a_rvalid_q <= 1'b0;
      b_rvalid_q <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      a_rvalid_q <= w_grant_a & ~a_we_i;
      b_rvalid_q <= w_grant_b & ~b_we_i;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_iob_2p_mem_arbiter.sv
// ============================================================================
// Module      : tb_iob_2p_mem_arbiter
// Description : Directed self-checking bench for iob_2p_mem_arbiter with a
//               behavioural 1-cycle-read memory (MEM_ARB_BURST_EN aware).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_iob_2p_mem_arbiter;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 14;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              a_valid, a_ready, a_we, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic              b_valid, b_ready, b_we, b_rvalid;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdata;
  logic [DATA_W-1:0] rdata;
  logic              mem_w_en, mem_r_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_in, mem_data_out;

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  iob_2p_mem_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid_i(a_valid), .a_ready_o(a_ready), .a_we_i(a_we),
    .a_addr_i(a_addr), .a_wdata_i(a_wdata), .a_rvalid_o(a_rvalid),
    .b_valid_i(b_valid), .b_ready_o(b_ready), .b_we_i(b_we),
    .b_addr_i(b_addr), .b_wdata_i(b_wdata), .b_rvalid_o(b_rvalid),
    .rdata_o(rdata),
    .mem_w_en_o(mem_w_en), .mem_r_en_o(mem_r_en),
    .mem_addr_o(mem_addr), .mem_data_in_o(mem_data_in),
    .mem_data_out_i(mem_data_out)
  );

  // Behavioural single-port memory with registered read data.
  always @(posedge clk) begin
    if (mem_w_en) mem_q[mem_addr] <= mem_data_in;
    if (mem_r_en) mem_data_out <= mem_q[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    cyc();
    rst_n = 1'b1;
  endtask

  // Five single-port reads from base..base+4; first nw hold dbase+i, rest 0.
  task automatic read_seq(input bit use_b, input int base, input int dbase, input int nw);
    a_valid = 1'b0; b_valid = 1'b0;
    for (int j = 0; j <= 5; j++) begin
      if (j < 5) begin
        if (use_b) begin b_valid = 1'b1; b_we = 1'b0; b_addr = ADDR_W'(base + j); end
        else       begin a_valid = 1'b1; a_we = 1'b0; a_addr = ADDR_W'(base + j); end
      end else begin
        a_valid = 1'b0; b_valid = 1'b0;
      end
      @(negedge clk);
      if (j > 0) begin
        chk("rb_rvalid", use_b ? b_rvalid : a_rvalid, 1);
        chk("rb_rdata", rdata, (j - 1 < nw) ? dbase + j - 1 : 0);
      end
      cyc();
    end
  endtask

  initial begin
    int ia, ib;
    bit exp_a;
    for (int i = 0; i < (1 << ADDR_W); i++) mem_q[i] = '0;
    rst_n = 1'b0; a_valid = 1'b1; b_valid = 1'b1;
    a_we = 1'b0; b_we = 1'b0; a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

    // Reset with both requesters active.
    cyc();
    for (int r = 0; r < 3; r++) begin
      @(negedge clk);
      chk("rst_a_ready", a_ready, 0);
      chk("rst_b_ready", b_ready, 0);
      chk("rst_w_en", mem_w_en, 0);
      chk("rst_r_en", mem_r_en, 0);
      chk("rst_a_rvalid", a_rvalid, 0);
      chk("rst_b_rvalid", b_rvalid, 0);
      cyc();
    end

    // Port A fill then readback.
    rst_n = 1'b1; b_valid = 1'b0; a_valid = 1'b1; a_we = 1'b1;
    for (int i = 0; i < 16; i++) begin
      a_addr = ADDR_W'(i); a_wdata = DATA_W'(32 + i);
      @(negedge clk);
      chk("fill_a_ready", a_ready, 1);
      chk("fill_w_en", mem_w_en, 1);
      chk("fill_addr", mem_addr, i);
      cyc();
    end
    a_we = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a_addr = ADDR_W'(i);
      @(negedge clk);
      chk("rd_a_ready", a_ready, 1);
      chk("rd_r_en", mem_r_en, 1);
      chk("rd_b_rvalid", b_rvalid, 0);
      if (i > 0) begin
        chk("rd_a_rvalid", a_rvalid, 1);
        chk("rd_rdata", rdata, i + 31);
      end
      cyc();
    end
    a_valid = 1'b0;
    @(negedge clk);
    chk("rd_last_rvalid", a_rvalid, 1);
    chk("rd_last_rdata", rdata, 47);
    cyc();

    // Contention right after reset: A read 3, B read 7.
    do_reset();
    a_valid = 1'b1; a_we = 1'b0; a_addr = 3;
    b_valid = 1'b1; b_we = 1'b0; b_addr = 7;
    @(negedge clk);
    chk("cont_a_ready", a_ready, 1);
    chk("cont_b_ready0", b_ready, 0);
    chk("cont_addr", mem_addr, 3);
    cyc();
    a_valid = 1'b0;
    @(negedge clk);
    chk("cont_b_ready1", b_ready, 1);
    chk("cont_a_rvalid", a_rvalid, 1);
    chk("cont_rdata_a", rdata, 35);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    chk("cont_b_rvalid", b_rvalid, 1);
    chk("cont_a_rvalid_off", a_rvalid, 0);
    chk("cont_rdata_b", rdata, 39);
    cyc();

    // Sustained tie of writes.
    do_reset();
    ia = 0; ib = 0;
    a_valid = 1'b1; b_valid = 1'b1; a_we = 1'b1; b_we = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_addr = ADDR_W'(100 + ia); a_wdata = DATA_W'(16'hA000 + ia);
      b_addr = ADDR_W'(200 + ib); b_wdata = DATA_W'(16'hB000 + ib);
      @(negedge clk);
`ifdef MEM_ARB_BURST_EN
      exp_a = (k < 4);
`else
      exp_a = (k % 2 == 0);
`endif
      chk("tie_a_ready", a_ready, exp_a);
      chk("tie_b_ready", b_ready, !exp_a);
      if (a_ready) ia++;
      if (b_ready) ib++;
      cyc();
    end
    chk("tie_a_count", ia, 4);
    chk("tie_b_count", ib, 4);
    read_seq(1'b0, 100, 16'hA000, 4);
    read_seq(1'b1, 200, 16'hB000, 4);

    // Write then read of the same address from the other port.
    a_valid = 1'b1; a_we = 1'b1; a_addr = 5; a_wdata = 16'h1234;
    cyc();
    a_valid = 1'b0; b_valid = 1'b1; b_we = 1'b0; b_addr = 5;
    @(negedge clk);
    chk("haz_b_ready", b_ready, 1);
    cyc();
    b_valid = 1'b0;
    @(negedge clk);
    chk("haz_b_rvalid", b_rvalid, 1);
    chk("haz_rdata", rdata, 16'h1234);
    cyc();

    // Reset asserted while A presents a read.
    a_valid = 1'b1; a_we = 1'b0; a_addr = 2;
    cyc();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mrst_a_ready", a_ready, 0);
    chk("mrst_r_en", mem_r_en, 0);
    cyc();
    rst_n = 1'b1; a_valid = 1'b0;
    @(negedge clk);
    chk("mrst_a_rvalid", a_rvalid, 0);
    cyc();
    a_valid = 1'b1; b_valid = 1'b1; b_we = 1'b0; b_addr = 7;
    @(negedge clk);
    chk("mrst_prio_a", a_ready, 1);
    chk("mrst_prio_b", b_ready, 0);
    cyc();
    a_valid = 1'b0; b_valid = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/iob_2p_mem_arbiter.md
Name: iob_2p_mem_arbiter

Overview:
- Two-requester round-robin arbiter for one iob_2p_mem_tiled instance: memory accesses are single-address, one access per cycle, and reads have 1-cycle latency.
- Each requester issues valid/ready read or write requests. The arbiter grants at most one per cycle, drives the memory's w_en/r_en/addr/data_in, and returns read data with a per-port response strobe.
- Sits between two datapath masters (for example, a DMA engine and a CPU port) and the tiled memory.

Parameters:
- DATA_W, 16, data width; must equal the memory DATA_W.
- ADDR_W, 14, address width; must equal the memory address width.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- a_valid  in  1  port A request valid.
- a_ready  out  1  port A request accepted this cycle.
- a_we  in  1  port A: 1 = write, 0 = read.
- a_addr  in  ADDR_W  port A address.
- a_wdata  in  DATA_W  port A write data.
- a_rvalid  out  1  port A read data valid.
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid: same as port A, for port B.
- rdata  out  DATA_W  shared read data (memory data_out passthrough); qualified by a_rvalid/b_rvalid.
- mem_w_en  out  1  to memory w_en.
- mem_r_en  out  1  to memory r_en.
- mem_addr  out  ADDR_W  to memory addr.
- mem_data_in  out  DATA_W  to memory data_in.
- mem_data_out  in  DATA_W  from memory data_out.

Behaviour:
- Reset (rst_n=0 at posedge):
  - prio <= A, meaning A wins the next tie.
  - a_rvalid, b_rvalid <= 0; burst counter <= 0.
  - While rst_n=0, a_ready, b_ready, mem_w_en and mem_r_en are forced to 0 combinationally.
- Grant (combinational, same cycle):
  - Only A valid -> A; only B valid -> B.
  - Both valid -> port indicated by prio.
  - Neither valid -> no grant.
  - x_ready = grant_x. Transfer = x_valid & x_ready. No combinational path from ready to valid.
- Memory drive:
  - mem_addr and mem_data_in are muxed from the granted port; with no grant they hold port A's values (don't care).
  - mem_w_en = xfer & we; mem_r_en = xfer & ~we.
- Priority update on each posedge with a transfer: prio <= the port that did NOT win. With no transfer, prio holds.
- Read response:
  - x_rvalid <= 1 on the posedge after a read transfer from port x, otherwise 0.
  - rdata = mem_data_out in the same cycle. Latency is exactly 1 cycle; at most one rvalid is high per cycle.
- Writes produce no response. A read of the same address on the cycle after a write returns the new data.
- Back-to-back: one transfer per cycle sustained. With both ports continuously valid, grants alternate A,B,A,B...
- A request must hold valid/we/addr/wdata stable until ready. Dropping valid before ready is allowed and leaves no side effect.
- Reset mid-operation: a read accepted in the cycle where rst_n is sampled low produces no rvalid. The memory contents are untouched by the arbiter.
- No FIFOs: requesters must accept the response unconditionally (no response backpressure).

Optional Feature:
- Macro: MEM_ARB_BURST_EN.
- Defined: adds localparam BURST_LEN=4 and a 2-bit burst counter.
  - After a port wins, it keeps priority for up to BURST_LEN consecutive transfers while it stays valid, even if the other port is valid.
  - The counter increments per transfer by the owner. It clears when ownership changes or the owner drops valid.
  - On reaching BURST_LEN, prio flips to the other port.
- Not defined: pure per-transfer round-robin as above; no burst counter is synthesized.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with a_valid=b_valid=1 -> a_ready=b_ready=mem_w_en=mem_r_en=0, a_rvalid=b_rvalid=0.
- Single-port fill/readback: port A writes addr 0..15 with data 32..47, then reads 0..15 -> a_ready=1 every cycle; a_rvalid one cycle after each read with rdata=addr+32; b_rvalid never asserted.
- Contention: both ports valid from the first cycle after reset. A reads addr 3, B reads addr 7 (preloaded 35, 39) -> A granted first, B next cycle; a_rvalid with rdata=35, then b_rvalid with rdata=39.
- Sustained tie: both ports valid for 8 cycles of writes (A to addr 100+i, B to addr 200+i) -> grants strictly alternate A,B,... Read back from both ranges shows 4 writes per port.
  - With MEM_ARB_BURST_EN: the order is A×4 then B×4.
- Write-then-read hazard: A writes 0x1234 to addr 5; B reads addr 5 on the next cycle -> b_rvalid with rdata=0x1234.
- Reset mid-read: A reads addr 2 in the same cycle rst_n is sampled low -> no a_rvalid in the following cycle; prio=A after reset.
